stride_seq: RTL and testbench

Parametrised stride-sequence generator, the successor to the fixed 8-bit add-7 bit-reversed counter. It produces a burst of `cfg_len` samples, or a free-running stream, from a seed and step captured at `start`. It supports four output code mappings and a valid/ready output handshake with stall. It sits in the stimulus/address-generation path and feeds downstream consumers that may apply backpressure.

---
 rtl/stride_seq_pkg.sv | 15 +
 rtl/seq_code_map.sv | 35 +++
 rtl/stride_seq.sv | 90 +++++++++
 tb/tb_stride_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stride_seq_pkg.sv
// Shared definitions for the stride sequence generator: output code
// selectors and the control FSM state encoding.
package stride_seq_pkg;

  localparam logic [1:0] MODE_BIN     = 2'd0;
  localparam logic [1:0] MODE_REV     = 2'd1;
  localparam logic [1:0] MODE_GRAY    = 2'd2;
  localparam logic [1:0] MODE_REVGRAY = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_code_map.sv
// Combinational value-to-code mapping (binary, bit-reversed, Gray,
// bit-reversed Gray), shared by sequence generators.
module seq_code_map
  import stride_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] code
);

  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] rev_bin;
  logic [WIDTH-1:0] rev_gray;

  assign gray = value ^ (value >> 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rev_bin[i]  = value[WIDTH-1-i];
    assign rev_gray[i] = gray[WIDTH-1-i];
  end

  always_comb begin
    code = value;
    case (mode)
      MODE_BIN:     code = value;
      MODE_REV:     code = rev_bin;
      MODE_GRAY:    code = gray;
      MODE_REVGRAY: code = rev_gray;
      default:      code = value;
    endcase
  end

endmodule

// File: rtl/stride_seq.sv
// Stride sequence generator: bursts or free-running streams of
// accumulator samples, mapped to an output code, with valid/ready stall.
module stride_seq
  import stride_seq_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               LEN_W    = 16,
  parameter logic [WIDTH-1:0] STEP_RST = WIDTH'(7)
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]       cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             wrap,
  output logic             busy,
  output state_t           dbg_state
);

  // Output handshake: a sample moves when out_valid and out_ready are both
  // high at a rising clk edge; while out_valid is high and out_ready is low,
  // out_data and out_last hold. out_valid never depends on out_ready.

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] step_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] remain;
  logic [WIDTH:0]   sum;
  logic             xfer;
  logic             at_last;

  assign sum     = {1'b0, acc} + {1'b0, step_q};
  assign xfer    = out_valid & out_ready;
  assign at_last = (remain == LEN_W'(1));

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state  <= ST_IDLE;
      acc    <= '0;
      step_q <= STEP_RST;
      mode_q <= MODE_BIN;
      remain <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start has priority over a simultaneous stop here
          if (start) begin
            state  <= ST_RUN;
            acc    <= cfg_seed;
            step_q <= cfg_step;
            mode_q <= cfg_mode;
            remain <= cfg_len;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            acc  <= sum[WIDTH-1:0];
            wrap <= sum[WIDTH];
            if (remain != '0) remain <= remain - LEN_W'(1);
          end
          // a transfer coinciding with stop still completes above
          if (stop || (xfer && at_last)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state == ST_RUN);
  assign busy      = out_valid;
  assign out_last  = out_valid & at_last;
  assign dbg_state = state;

  seq_code_map #(.WIDTH(WIDTH)) u_map (
    .mode  (mode_q),
    .value (acc),
    .code  (out_data)
  );

endmodule

// File: tb/tb_stride_seq.sv
// Directed bench for stride_seq: expected samples are queued at start and
// popped against every accepted output transfer.
module tb_stride_seq;
  import stride_seq_pkg::*;

  localparam int W = 8;
  localparam int L = 16;

  logic         clk;
  logic         init;
  logic [W-1:0] cfg_seed;
  logic [W-1:0] cfg_step;
  logic [L-1:0] cfg_len;
  logic [1:0]   cfg_mode;
  logic         start;
  logic         stop;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         wrap;
  logic         busy;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int xfer_mark = 0;
  logic [W:0] exp_q[$];

  stride_seq #(.WIDTH(W), .LEN_W(L), .STEP_RST(8'd7)) dut (
    .clk       (clk),
    .init      (init),
    .cfg_seed  (cfg_seed),
    .cfg_step  (cfg_step),
    .cfg_len   (cfg_len),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .wrap      (wrap),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic last, input logic [W-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input logic [W-1:0] seed, input logic [W-1:0] step,
                             input logic [1:0] mode, input logic [L-1:0] len);
    cfg_seed = seed;
    cfg_step = step;
    cfg_mode = mode;
    cfg_len  = len;
    start    = 1'b1;
  endtask

  // scoreboard: every accepted sample must match the head of exp_q
  always @(negedge clk) begin
    logic [W:0] e;
    if (!init && out_valid && out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_xfer", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[W-1:0]));
        chk("sb_last", 32'(out_last), 32'(e[W]));
      end
    end
  end

  initial begin
    init = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    cfg_seed = '0; cfg_step = 8'd7; cfg_mode = 2'd0; cfg_len = '0;

    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_wrap",  32'(wrap), 0);
    chk("rst_last",  32'(out_last), 0);
    chk("rst_data",  32'(out_data), 0);
    tick(); tick();
    init = 1'b0;
    tick();

    // legacy add-7 bit-reversed stream, ended by stop on the 4th transfer
    push(0, 8'h00); push(0, 8'hE0); push(0, 8'h70); push(0, 8'hA8);
    begin_burst(8'h00, 8'd7, MODE_REV, 16'd0);
    tick(); start = 1'b0;
    chk("leg_valid", 32'(out_valid), 1);
    chk("leg_busy",  32'(busy), 1);
    tick(); tick(); tick();
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk("leg_end_valid", 32'(out_valid), 0);
    chk("leg_end_busy",  32'(busy), 0);

    // wrap and burst end
    push(0, 8'hFA); push(0, 8'h01); push(1, 8'h08);
    begin_burst(8'hFA, 8'd7, MODE_BIN, 16'd3);
    tick(); start = 1'b0;
    chk("wr_data0", 32'(out_data), 32'hFA);
    chk("wr_wrap0", 32'(wrap), 0);
    tick();
    chk("wr_data1", 32'(out_data), 32'h01);
    chk("wr_wrap1", 32'(wrap), 1);
    tick();
    chk("wr_wrap2", 32'(wrap), 0);
    chk("wr_last2", 32'(out_last), 1);
    tick();
    chk("wr_end_valid", 32'(out_valid), 0);
    chk("wr_end_busy",  32'(busy), 0);
    chk("wr_end_last",  32'(out_last), 0);
    chk("wr_end_wrap",  32'(wrap), 0);

    // backpressure: 3 stalled cycles after the first transfer
    xfer_mark = xfer_cnt;
    push(0, 8'h10); push(0, 8'h11); push(0, 8'h12); push(1, 8'h13);
    begin_burst(8'h10, 8'd1, MODE_BIN, 16'd4);
    tick(); start = 1'b0;
    chk("bp_data0", 32'(out_data), 32'h10);
    tick(); out_ready = 1'b0;
    chk("bp_hold0", 32'(out_data), 32'h11);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk("bp_hold", 32'(out_data), 32'h11);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_last", 32'(out_last), 0);
    end
    tick(); out_ready = 1'b1;
    chk("bp_hold3", 32'(out_data), 32'h11);
    tick();
    chk("bp_data2", 32'(out_data), 32'h12);
    tick();
    chk("bp_data3", 32'(out_data), 32'h13);
    chk("bp_last3", 32'(out_last), 1);
    tick();
    chk("bp_end_valid", 32'(out_valid), 0);
    chk("bp_xfers", 32'(xfer_cnt - xfer_mark), 4);

    // Gray mapping
    push(0, 8'h07); push(0, 8'h05); push(1, 8'h04);
    begin_burst(8'h05, 8'd1, MODE_GRAY, 16'd3);
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("gray_end_valid", 32'(out_valid), 0);

    // bit-reversed Gray mapping
    push(0, 8'h80); push(1, 8'hC0);
    begin_burst(8'h01, 8'd1, MODE_REVGRAY, 16'd2);
    tick(); start = 1'b0;
    tick(); tick();
    chk("rg_end_valid", 32'(out_valid), 0);

    // start with new config during RUN is ignored
    push(0, 8'h20); push(0, 8'h23); push(0, 8'h26);
    begin_burst(8'h20, 8'd3, MODE_BIN, 16'd0);
    tick();
    begin_burst(8'h80, 8'h55, MODE_REV, 16'd1);
    tick(); start = 1'b0;
    chk("ign_data1", 32'(out_data), 32'h23);
    chk("ign_last1", 32'(out_last), 0);
    tick();
    chk("ign_data2", 32'(out_data), 32'h26);
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk("ign_end_valid", 32'(out_valid), 0);

    // stop coinciding with a carrying transfer
    push(0, 8'hF9);
    begin_burst(8'hF9, 8'd7, MODE_BIN, 16'd0);
    tick(); start = 1'b0; stop = 1'b1;
    chk("stx_data", 32'(out_data), 32'hF9);
    tick(); stop = 1'b0;
    chk("stx_valid", 32'(out_valid), 0);
    chk("stx_wrap", 32'(wrap), 1);
    tick();
    chk("stx_wrap_gone", 32'(wrap), 0);

    // stop alone in IDLE ignored; start+stop in IDLE starts
    stop = 1'b1;
    tick();
    chk("idle_stop_valid", 32'(out_valid), 0);
    push(0, 8'h40); push(1, 8'h42);
    begin_burst(8'h40, 8'd2, MODE_BIN, 16'd2);
    tick(); start = 1'b0; stop = 1'b0;
    chk("ss_valid", 32'(out_valid), 1);
    chk("ss_data", 32'(out_data), 32'h40);
    tick(); tick();
    chk("ss_end_valid", 32'(out_valid), 0);

    // step 0: constant output, never wraps
    push(0, 8'hFF); push(0, 8'hFF); push(1, 8'hFF);
    begin_burst(8'hFF, 8'd0, MODE_BIN, 16'd3);
    tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s0_wrap", 32'(wrap), 0);
    end
    chk("s0_end_valid", 32'(out_valid), 0);

    // asynchronous reset in the middle of a run
    push(0, 8'hFF);
    begin_burst(8'hFF, 8'd2, MODE_BIN, 16'd0);
    tick(); start = 1'b0;
    chk("ar_data0", 32'(out_data), 32'hFF);
    tick();
    chk("ar_wrap_pre", 32'(wrap), 1);
    chk("ar_data_pre", 32'(out_data), 32'h01);
    #1 init = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_busy",  32'(busy), 0);
    chk("ar_wrap",  32'(wrap), 0);
    chk("ar_data",  32'(out_data), 0);
    tick(); tick();
    init = 1'b0;
    tick();

    // restart after reset with step 7 and bit-reversed output
    push(0, 8'h00); push(1, 8'hE0);
    begin_burst(8'h00, 8'd7, MODE_REV, 16'd2);
    tick(); start = 1'b0;
    tick(); tick();
    chk("post_valid", 32'(out_valid), 0);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
